// File: rtl/signed_adder_subtractor_pkg.sv
// Shared constants for the signed adder/subtractor: default width, operation codes, clamp limits.
package signed_adder_subtractor_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 16;
  localparam int unsigned MAX_WIDTH     = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Largest positive two's-complement value of width w, zero-extended to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] sat_pos_limit(input int unsigned w);
    return (MAX_WIDTH'(1) << (w - 1)) - MAX_WIDTH'(1);
  endfunction

  // Most negative two's-complement value of width w (only bit w-1 set).
  function automatic logic [MAX_WIDTH-1:0] sat_neg_limit(input int unsigned w);
    return MAX_WIDTH'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/signed_adder_subtractor_full_adder.sv
// One-bit full adder cell of the ripple chain; purely combinational, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/signed_adder_subtractor.sv
// Registered ripple-carry a+b / a-b with signed overflow; 1-cycle latency, no back-pressure.
// Define ADDSUB_SATURATE_EN to clamp overflowing results instead of wrapping.
module signed_adder_subtractor
  import signed_adder_subtractor_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 operation,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 overflow
);

  logic [BIT_WIDTH-1:0] bx;
  logic [BIT_WIDTH-1:0] sum;
  logic [BIT_WIDTH:0]   carry;
  logic                 ovf;
  logic [BIT_WIDTH-1:0] next_result;

  // Subtraction is a + ~b + 1: invert b and feed the operation bit in as carry.
  assign bx       = b ^ {BIT_WIDTH{operation}};
  assign carry[0] = (operation == OP_SUB);

  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (bx[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign ovf = carry[BIT_WIDTH-1] ^ carry[BIT_WIDTH];

`ifdef ADDSUB_SATURATE_EN
  localparam logic [MAX_WIDTH-1:0] SAT_POS_FULL = sat_pos_limit(BIT_WIDTH);
  localparam logic [MAX_WIDTH-1:0] SAT_NEG_FULL = sat_neg_limit(BIT_WIDTH);
  localparam logic [BIT_WIDTH-1:0] SAT_POS      = SAT_POS_FULL[BIT_WIDTH-1:0];
  localparam logic [BIT_WIDTH-1:0] SAT_NEG      = SAT_NEG_FULL[BIT_WIDTH-1:0];

  // On overflow the true result shares the sign of a, which picks the rail.
  always_comb begin
    next_result = sum;
    if (ovf) begin
      next_result = a[BIT_WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end
`else
  assign next_result = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= next_result;
        overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_signed_adder_subtractor.sv
// Directed + random-stream bench for signed_adder_subtractor; honours ADDSUB_SATURATE_EN.
module tb_signed_adder_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        operation;
  logic        out_valid;
  logic [15:0] result;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_res;
  logic        exp_ovf;
  logic [16:0] m;

  signed_adder_subtractor #(.BIT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .operation (operation),
    .out_valid (out_valid),
    .result    (result),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference built from operand/result sign rules, returns {overflow, result}.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic op);
    logic [15:0] r;
    logic        o;
    if (op) begin
      r = x - y;
      o = (x[15] != y[15]) && (r[15] != x[15]);
    end else begin
      r = x + y;
      o = (x[15] == y[15]) && (r[15] != x[15]);
    end
`ifdef ADDSUB_SATURATE_EN
    if (o) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, r};
  endfunction

  task automatic step(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                      input logic op, input logic [15:0] er, input logic eo);
    a = ia; b = ib; operation = op; in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; operation = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_res", 32'(result), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      a = 16'($urandom); b = 16'($urandom);
    end
    rst = 1'b0;

    step("add1", 16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0);
    step("add2", 16'h1000, 16'hF800, 1'b0, 16'h0800, 1'b0);
    step("add3", 16'hF000, 16'hE000, 1'b0, 16'hD000, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    step("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1);
`else
    step("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
`endif
    step("sub1", 16'h5678, 16'h1234, 1'b1, 16'h4444, 1'b0);
    step("sub2", 16'h1000, 16'hF000, 1'b1, 16'h2000, 1'b0);
    step("sub3", 16'hF000, 16'h1000, 1'b1, 16'hE000, 1'b0);
    step("sub4", 16'h0000, 16'h1234, 1'b1, 16'hEDCC, 1'b0);
    step("sub_self", 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    step("sub_ovf_neg", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1);
    step("sub_ovf_min", 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
`else
    step("sub_ovf_neg", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);
    step("sub_ovf_min", 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1);
`endif
    step("mix_add", 16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b0);

    // Back-to-back stream, alternating add/sub.
    for (int i = 0; i < 100; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 10 == 3) ra = 16'h7FFF;
      if (i % 10 == 7) ra = 16'h8000;
      m = model(ra, rb, 1'(i % 2));
      exp_res = m[15:0];
      exp_ovf = m[16];
      step("stream", ra, rb, 1'(i % 2), exp_res, exp_ovf);
    end

    // Idle: outputs hold even while operands change.
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 16'($urandom); b = 16'($urandom); operation = 1'($urandom);
      @(posedge clk); #1;
      check("idle_vld", 32'(out_valid), 32'd0);
      check("idle_res", 32'(result), 32'(exp_res));
      check("idle_ovf", 32'(overflow), 32'(exp_ovf));
    end

    // Reset in the middle of a stream discards the in-flight operation.
    step("pre_rst", 16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0);
    a = 16'h7FFF; b = 16'h0001; operation = 1'b0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_vld", 32'(out_valid), 32'd0);
    check("midrst_res", 32'(result), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    step("post_rst", 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("final_vld", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_adder_subtractor.md
Name: signed_adder_subtractor

Overview:
Registered two's-complement adder/subtractor for the matrix-multiply datapath, used for MAC accumulation and element differences. It computes a+b or a−b, with one-cycle latency and a signed-overflow flag. It is built structurally as a ripple-carry adder: operand b is conditionally inverted and the carry-in is driven by the operation bit.

Parameters:
BIT_WIDTH, 16, operand/result width in bits (two's complement); legal range ≥2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands/operation valid this cycle
a  input  BIT_WIDTH  signed operand A
b  input  BIT_WIDTH  signed operand B
operation  input  1  0 = add (a+b), 1 = subtract (a−b)
out_valid  output  1  result/overflow valid
result  output  BIT_WIDTH  signed sum/difference
overflow  output  1  signed overflow of the latched operation

Behaviour:
- Reset: on a rising clk edge with rst=1, result=0, overflow=0, out_valid=0. rst has priority over in_valid.
- Latency: exactly 1 cycle. Inputs are sampled at the clk edge where in_valid=1. result, overflow and out_valid update at that edge.
- No back-pressure. Every in_valid=1 cycle produces out_valid=1 on the next cycle.
- When in_valid=0: out_valid falls to 0 at the next edge; result and overflow hold their last values.
- Datapath:
  - bx = b XOR {BIT_WIDTH{operation}}; cin = operation.
  - Ripple chain of BIT_WIDTH full-adder cells computes a + bx + cin.
  - Raw result is the low BIT_WIDTH bits, so wrap-around is modulo 2^BIT_WIDTH.
- Overflow = carry into MSB XOR carry out of MSB. Equivalently:
  - add: sign(a)==sign(b) and sign(sum)≠sign(a);
  - sub: sign(a)≠sign(b) and sign(diff)≠sign(a).
- Unsigned carry-out is not a port and does not affect overflow.
- Boundaries:
  - 0x7FFF+1 → 0x8000, overflow=1.
  - 0x8000−1 → 0x7FFF, overflow=1.
  - 0−0x8000 → 0x8000, overflow=1 (negating the most-negative value).
  - x−x → 0, overflow=0.
  - Mixed-sign add and same-sign subtract never overflow.
- Reset asserted mid-stream: the in-flight operation is discarded and out_valid=0 on the following cycle.
- No X propagation from a/b when in_valid=0; registers load only on in_valid.

Optional Feature:
Macro ADDSUB_SATURATE_EN.
- Defined: when overflow=1, result clamps instead of wrapping. Positive overflow gives 2^(BIT_WIDTH−1)−1 (0x7FFF); negative overflow gives −2^(BIT_WIDTH−1) (0x8000). The overflow flag is still asserted. Clamp direction comes from sign(a).
- Undefined: result wraps modulo 2^BIT_WIDTH as above. No saturation logic is synthesized.

Decomposition:
- Shared package:
  - BIT_WIDTH default (16);
  - operation encodings OP_ADD=1'b0 and OP_SUB=1'b1;
  - saturation limit constants derived from BIT_WIDTH.
- One natural sub-module, full_adder (1-bit: a, b, cin → sum, cout), instantiated BIT_WIDTH times via generate. MSB carry-in/carry-out are exposed internally for overflow detection.
- Input registers, output registers and saturation mux stay in the top module.

Test Plan:
- Drive rst=1 for 2 cycles with random a/b and in_valid=1 → result=0x0000, overflow=0, out_valid=0 throughout.
- Add: 0x1234+0x5678 → 0x68AC, overflow=0. 0x1000+(−0x0800) → 0x0800, overflow=0. (−0x1000)+(−0x2000) → 0xD000, overflow=0. Each response appears one cycle after in_valid.
- Overflow on add: 0x7FFF+0x0001 → 0x8000 with overflow=1. With ADDSUB_SATURATE_EN → 0x7FFF with overflow=1.
- Subtract: 0x5678−0x1234 → 0x4444. 0x1000−(−0x1000) → 0x2000. (−0x1000)−0x1000 → 0xE000. 0x0000−0x1234 → 0xEDCC. All with overflow=0.
- Overflow on subtract: 0x8000−0x0001 → 0x7FFF, overflow=1. 0x0000−0x8000 → 0x8000, overflow=1. With saturation → 0x8000 and 0x7FFF respectively.
- Streaming: back-to-back in_valid with alternating operation for 100 random vectors, compared against a reference model (wrap, or saturate when the macro is defined). Then drop in_valid → out_valid=0 and result holds. Assert rst mid-stream → out_valid=0 next cycle.
